// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder datapath: default operand width and
// the operand feeder state encoding.
package serial_pkg;

    localparam int unsigned SERIAL_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SHIFT
    } feeder_state_t;

endpackage

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand front end: accepts a W-bit operand pair plus a length
// and streams it LSB-first, one bit pair per cycle, honouring a downstream pause.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int unsigned W = SERIAL_W_DEFAULT,
    localparam int unsigned LEN_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [LEN_W-1:0] in_len,
    input  logic             pause,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last,
    output logic             busy
);

    feeder_state_t    state, state_d;
    logic [W-1:0]     sh_a, sh_a_d;
    logic [W-1:0]     sh_b, sh_b_d;
    logic [LEN_W-1:0] cnt, cnt_d;

    logic in_fire;

    // in_rdy depends only on state and rst, never on in_vld.
    assign in_rdy  = (state == ST_IDLE) && !rst;
    assign in_fire = in_vld && in_rdy;

    always_comb begin
        busy = (state == ST_SHIFT);
        vld  = busy && !pause;
        a    = vld && sh_a[0];
        b    = vld && sh_b[0];
        last = vld && (cnt == '0);
    end

    always_comb begin
        state_d = state;
        sh_a_d  = sh_a;
        sh_b_d  = sh_b;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                    cnt_d   = in_len;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (vld && last) begin
                    state_d = ST_IDLE;
                end else if (vld) begin
                    sh_a_d = {1'b0, sh_a[W-1:1]};
                    sh_b_d = {1'b0, sh_b[W-1:1]};
                    cnt_d  = cnt - LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sh_a  <= sh_a_d;
            sh_b  <= sh_b_d;
            cnt   <= cnt_d;
        end
    end

endmodule
